hash_stream_engine: RTL and testbench
=====================================

// Module: hash_stream_engine
// PURPOSE
//  Sequential, parametrised successor to the fixed 6-byte combinational hash: absorbs a byte stream of any length
//  (1..MAX_BYTES) over a valid/ready handshake, one byte per clock. It mixes each byte into four WORD_W state words
//  (a,b,c,d), runs FINAL_ROUNDS finalisation rounds, then presents the digest on a held valid/ready output.
//  Sits between the byte source (UART/keypad capture) and the digest compare/display logic.
// PARAMETERS
//  WORD_W        16       width of each state word a/b/c/d
//  MAX_BYTES     64       max message length; longer messages flag h_err
//  LEN_W         8        width of byte counter/h_len (must hold MAX_BYTES)
//  FINAL_ROUNDS  4        finalisation rounds after last byte (>=1)
//  IV_A..IV_D    16'h6745,16'hEFCD,16'h98BA,16'h1032   state init values (truncated/zero-extended to WORD_W)
//  K             16'h9E37 round constant
// PORTS
//  clk      in   1        rising-edge clock
//  rst_n    in   1        synchronous active-low reset
//  s_valid  in   1        input byte valid
//  s_ready  out  1        engine accepts byte this cycle
//  s_data   in   8        message byte
//  s_last   in   1        qualifies final byte of message
//  h_valid  out  1        digest valid (held until h_ready)
//  h_ready  in   1        consumer accepts digest
//  h_a..h_d out  WORD_W   digest words
//  h_len    out  LEN_W    bytes absorbed (saturates at MAX_BYTES)
//  h_err    out  1        message exceeded MAX_BYTES
// BEHAVIOUR
//  Reset: one clock and reset; reset is synchronous and active-low. On rst_n=0 at a clk edge:
//   state=IDLE, a..d=IV, count=0, err=0, s_ready=0, h_valid=0, h_a..h_d=0, h_len=0, h_err=0.
//   Reset mid-message or mid-digest discards everything; no digest is produced for that message.
//  FSM: IDLE -> ABSORB -> FINAL -> DONE -> IDLE.
//   IDLE  : s_ready=1; on s_valid, absorb byte, count=1, go ABSORB (or FINAL if s_last).
//   ABSORB: s_ready=1; each s_valid&s_ready absorbs one byte, count++; on s_last go FINAL.
//           No s_valid => state holds (bubbles allowed).
//   FINAL : s_ready=0; one round per cycle with x = count[7:0] ^ round_idx (round_idx 0..FINAL_ROUNDS-1);
//           after FINAL_ROUNDS cycles latch digest, go DONE.
//   DONE  : s_ready=0, h_valid=1, outputs stable; on h_ready, h_valid=0, state a..d=IV, count=0, err=0, go IDLE.
//  Latency: last byte accepted at edge T -> h_valid=1 after edge T+FINAL_ROUNDS. Throughput: 1 byte/clk in ABSORB.
//  Round (all mod 2^WORD_W, x = zero-extended byte):
//   a'=rotl(a^x,3)+d; b'=rotl(b+a',5)^c; c'=c+(b'^K); d'=rotl(d^c',1)+x.
//  Overflow: a byte accepted when count==MAX_BYTES sets err=1. Count saturates and the byte is still mixed.
//   h_err is reported with the digest.
//  s_last with s_valid=0 is ignored. h_ready while h_valid=0 is ignored. The first cycle after DONE is always IDLE.
//  s_data/s_last must be stable while s_valid=1 && s_ready=0 (source rule; checked by assertion).
// STRUCTURE
//  hash_pkg: state enum {IDLE,ABSORB,FINAL,DONE}, IV/K defaults, rotl function.
//  Sub-module hash_round: combinational round function (a,b,c,d,x -> a',b',c',d').
//   It is instanced once and shared by ABSORB and FINAL via an x mux.
//  Top: FSM, counters (count, round_idx), state regs, output regs.
// TESTING (bench compares against C model hash_model.c, same parameters)
//  1 Reset: hold rst_n=0 3 clks mid-ABSORB, release -> s_ready=1, h_valid=0. Next message digest equals model.
//  2 "ABCDEF" (41..46), back-to-back, s_last on 46 -> h_valid at 4 clks after last, h_len=6, h_err=0, words==model.
//  3 Same 6 bytes with random s_valid bubbles and h_ready held low 10 clks -> identical digest, outputs stable while held.
//  4 Single byte 8'h00 with s_last -> h_len=1, digest==model, h_valid exactly FINAL_ROUNDS clks after accept.
//  5 65 bytes of 8'hFF (MAX_BYTES=64) -> h_err=1, h_len=64, digest==model.
//  6 Two messages back-to-back, h_ready=1 -> second accepted starting the cycle after h_valid drops; no state bleed.

Source files
------------

// File: rtl/hash_stream_engine_pkg.sv
// ---------------------------------------------------------------------------
// hash_stream_engine_pkg
//
// Purpose:
//   Shared definitions for the streaming hash engine:
//   - the engine state enumeration,
//   - the default initial values (IV) for the four state words,
//   - the default round constant,
//   - a width-generic rotate-left helper.
//
// Ports:
//   none (package)
// ---------------------------------------------------------------------------
package hash_stream_engine_pkg;

  // Engine states. Each message goes through all four of them in order.
  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_ABSORB = 2'd1,
    STATE_FINAL  = 2'd2,
    STATE_DONE   = 2'd3
  } engineState_t;

  // The widest state word the rotate helper can handle.
  localparam int MAX_WORD_W = 32;

  // Default initial values for the four state words, and the round constant.
  // The top truncates or zero-extends these to the configured word width.
  localparam logic [15:0] DEFAULT_IV_A = 16'h6745;
  localparam logic [15:0] DEFAULT_IV_B = 16'hEFCD;
  localparam logic [15:0] DEFAULT_IV_C = 16'h98BA;
  localparam logic [15:0] DEFAULT_IV_D = 16'h1032;
  localparam logic [15:0] DEFAULT_K    = 16'h9E37;

  // Rotate the low 'width' bits of 'value' left by 'amount'.
  // Bits above 'width' are cleared on both input and output, so callers can
  // pass a narrower word that has been zero-extended to MAX_WORD_W.
  function automatic logic [MAX_WORD_W-1:0] rotl(
    input logic [MAX_WORD_W-1:0] value,
    input int                    width,
    input int                    amount
  );
    logic [MAX_WORD_W-1:0] mask;
    logic [MAX_WORD_W-1:0] field;
    if (width >= MAX_WORD_W) begin
      mask = '1;
    end else begin
      mask = (MAX_WORD_W'(1) << width) - MAX_WORD_W'(1);
    end
    field = value & mask;
    return ((field << amount) | (field >> (width - amount))) & mask;
  endfunction

endpackage

// File: rtl/hash_stream_engine_round.sv
// ---------------------------------------------------------------------------
// hash_stream_engine_round
//
// Purpose:
//   Purely combinational mixing round. It takes the four state words and one
//   mixing word x, and produces the next four state words. All arithmetic
//   wraps modulo 2^WORD_W.
//     a' = rotl(a ^ x, 3) + d
//     b' = rotl(b + a', 5) ^ c
//     c' = c + (b' ^ K)
//     d' = rotl(d ^ c', 1) + x
//
// Ports:
//   i_a..i_d  in   WORD_W  current state words
//   i_x       in   WORD_W  mixing word (zero-extended byte)
//   o_a..o_d  out  WORD_W  next state words
// ---------------------------------------------------------------------------
module hash_stream_engine_round
  import hash_stream_engine_pkg::*;
#(
  parameter int          WORD_W = 16,
  parameter logic [15:0] K      = DEFAULT_K
) (
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic [WORD_W-1:0] i_c,
  input  logic [WORD_W-1:0] i_d,
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_a,
  output logic [WORD_W-1:0] o_b,
  output logic [WORD_W-1:0] o_c,
  output logic [WORD_W-1:0] o_d
);

  localparam logic [WORD_W-1:0] K_W = WORD_W'(K);

  logic [WORD_W-1:0] w_aMix;
  logic [WORD_W-1:0] w_aNext;
  logic [WORD_W-1:0] w_bSum;
  logic [WORD_W-1:0] w_bNext;
  logic [WORD_W-1:0] w_cNext;
  logic [WORD_W-1:0] w_dMix;
  logic [WORD_W-1:0] w_dNext;

  // One full round. Each intermediate is held in a WORD_W-wide signal before
  // it is rotated. That way the sums wrap at the word width, and no carry
  // leaks into the wider rotate helper.
  always_comb begin
    w_aMix  = i_a ^ i_x;
    w_aNext = WORD_W'(rotl(MAX_WORD_W'(w_aMix), WORD_W, 3)) + i_d;
    w_bSum  = i_b + w_aNext;
    w_bNext = WORD_W'(rotl(MAX_WORD_W'(w_bSum), WORD_W, 5)) ^ i_c;
    w_cNext = i_c + (w_bNext ^ K_W);
    w_dMix  = i_d ^ w_cNext;
    w_dNext = WORD_W'(rotl(MAX_WORD_W'(w_dMix), WORD_W, 1)) + i_x;
  end

  // Drive the round results straight out.
  always_comb begin
    o_a = w_aNext;
    o_b = w_bNext;
    o_c = w_cNext;
    o_d = w_dNext;
  end

endmodule

// File: rtl/hash_stream_engine.sv
// ---------------------------------------------------------------------------
// hash_stream_engine
//
// Purpose:
//   Absorbs a byte stream of 1..MAX_BYTES bytes over a valid/ready handshake,
//   at one byte per clock. Each byte is mixed into four WORD_W state words.
//   After the last byte, the engine runs FINAL_ROUNDS finalisation rounds and
//   then holds the digest on a valid/ready output until it is taken.
//   A single shared round instance serves both the absorb and the final
//   phases; a mux picks the mixing byte for each phase.
//
// Ports:
//   i_clk       in   1       rising-edge clock
//   i_rst_n     in   1       synchronous active-low reset
//   i_s_valid   in   1       input byte valid
//   o_s_ready   out  1       engine accepts a byte this cycle
//   i_s_data    in   8       message byte
//   i_s_last    in   1       marks the final byte of the message
//   o_h_valid   out  1       digest valid (held until i_h_ready)
//   i_h_ready   in   1       consumer accepts the digest
//   o_h_a..d    out  WORD_W  digest words
//   o_h_len     out  LEN_W   bytes absorbed (saturates at MAX_BYTES)
//   o_h_err     out  1       message was longer than MAX_BYTES
// ---------------------------------------------------------------------------
module hash_stream_engine
  import hash_stream_engine_pkg::*;
#(
  parameter int          WORD_W       = 16,
  parameter int          MAX_BYTES    = 64,
  parameter int          LEN_W        = 8,
  parameter int          FINAL_ROUNDS = 4,
  parameter logic [15:0] IV_A         = DEFAULT_IV_A,
  parameter logic [15:0] IV_B         = DEFAULT_IV_B,
  parameter logic [15:0] IV_C         = DEFAULT_IV_C,
  parameter logic [15:0] IV_D         = DEFAULT_IV_D,
  parameter logic [15:0] K            = DEFAULT_K
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  input  logic [7:0]        i_s_data,
  input  logic              i_s_last,
  output logic              o_h_valid,
  input  logic              i_h_ready,
  output logic [WORD_W-1:0] o_h_a,
  output logic [WORD_W-1:0] o_h_b,
  output logic [WORD_W-1:0] o_h_c,
  output logic [WORD_W-1:0] o_h_d,
  output logic [LEN_W-1:0]  o_h_len,
  output logic              o_h_err
);

  localparam int RIDX_W = (FINAL_ROUNDS > 1) ? $clog2(FINAL_ROUNDS) : 1;
  localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(FINAL_ROUNDS - 1);
  localparam logic [LEN_W-1:0]  COUNT_MAX  = LEN_W'(MAX_BYTES);
  localparam logic [WORD_W-1:0] IV_A_W     = WORD_W'(IV_A);
  localparam logic [WORD_W-1:0] IV_B_W     = WORD_W'(IV_B);
  localparam logic [WORD_W-1:0] IV_C_W     = WORD_W'(IV_C);
  localparam logic [WORD_W-1:0] IV_D_W     = WORD_W'(IV_D);

  engineState_t      r_state;
  logic [WORD_W-1:0] r_a;
  logic [WORD_W-1:0] r_b;
  logic [WORD_W-1:0] r_c;
  logic [WORD_W-1:0] r_d;
  logic [LEN_W-1:0]  r_count;
  logic              r_err;
  logic [RIDX_W-1:0] r_roundIdx;
  logic              r_sReady;
  logic              r_hValid;
  logic [WORD_W-1:0] r_hA;
  logic [WORD_W-1:0] r_hB;
  logic [WORD_W-1:0] r_hC;
  logic [WORD_W-1:0] r_hD;
  logic [LEN_W-1:0]  r_hLen;
  logic              r_hErr;

  logic              w_accept;
  logic [7:0]        w_countByte;
  logic [7:0]        w_roundByte;
  logic [7:0]        w_xByte;
  logic [WORD_W-1:0] w_x;
  logic [WORD_W-1:0] w_aNext;
  logic [WORD_W-1:0] w_bNext;
  logic [WORD_W-1:0] w_cNext;
  logic [WORD_W-1:0] w_dNext;

  // Pick the mixing byte for the shared round.
  // In the final phase the byte is the low byte of the message length XORed
  // with the round index, so two messages that differ only in length still
  // finalise differently.
  // In every other state the incoming data byte is used. The result is only
  // committed when a byte is actually accepted.
  always_comb begin
    w_accept    = i_s_valid && r_sReady;
    w_countByte = 8'(r_count);
    w_roundByte = 8'(r_roundIdx);
    w_xByte     = (r_state == STATE_FINAL) ? (w_countByte ^ w_roundByte) : i_s_data;
    w_x         = WORD_W'(w_xByte);
  end

  hash_stream_engine_round #(
    .WORD_W (WORD_W),
    .K      (K)
  ) u_round (
    .i_a (r_a),
    .i_b (r_b),
    .i_c (r_c),
    .i_d (r_d),
    .i_x (w_x),
    .o_a (w_aNext),
    .o_b (w_bNext),
    .o_c (w_cNext),
    .o_d (w_dNext)
  );

  // Main control FSM. It also owns the hash state words, the byte counter,
  // the round index and every registered output.
  //
  // - s_ready is registered, so it stays low for one cycle after reset and
  //   rises as soon as the engine sits in IDLE.
  // - s_ready drops on the same edge that accepts the last byte.
  // - The digest is latched straight from the round outputs on the last
  //   final round. That makes h_valid appear exactly FINAL_ROUNDS edges after
  //   the last byte is accepted.
  // - Leaving DONE restores the IVs and re-raises s_ready on the same edge,
  //   so the next message can start on the very next cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= STATE_IDLE;
      r_a        <= IV_A_W;
      r_b        <= IV_B_W;
      r_c        <= IV_C_W;
      r_d        <= IV_D_W;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_roundIdx <= '0;
      r_sReady   <= 1'b0;
      r_hValid   <= 1'b0;
      r_hA       <= '0;
      r_hB       <= '0;
      r_hC       <= '0;
      r_hD       <= '0;
      r_hLen     <= '0;
      r_hErr     <= 1'b0;
    end else begin
      unique case (r_state)
        STATE_IDLE: begin
          r_sReady <= 1'b1;
          if (w_accept) begin
            r_a     <= w_aNext;
            r_b     <= w_bNext;
            r_c     <= w_cNext;
            r_d     <= w_dNext;
            r_count <= LEN_W'(1);
            r_err   <= 1'b0;
            if (i_s_last) begin
              r_state    <= STATE_FINAL;
              r_sReady   <= 1'b0;
              r_roundIdx <= '0;
            end else begin
              r_state <= STATE_ABSORB;
            end
          end
        end

        STATE_ABSORB: begin
          if (w_accept) begin
            r_a <= w_aNext;
            r_b <= w_bNext;
            r_c <= w_cNext;
            r_d <= w_dNext;
            // A byte arriving after the counter is full flags an overflow.
            // The counter saturates, but the byte is still mixed in.
            if (r_count == COUNT_MAX) begin
              r_err <= 1'b1;
            end else begin
              r_count <= r_count + LEN_W'(1);
            end
            if (i_s_last) begin
              r_state    <= STATE_FINAL;
              r_sReady   <= 1'b0;
              r_roundIdx <= '0;
            end
          end
        end

        STATE_FINAL: begin
          r_a        <= w_aNext;
          r_b        <= w_bNext;
          r_c        <= w_cNext;
          r_d        <= w_dNext;
          r_roundIdx <= r_roundIdx + RIDX_W'(1);
          if (r_roundIdx == LAST_ROUND) begin
            r_hA     <= w_aNext;
            r_hB     <= w_bNext;
            r_hC     <= w_cNext;
            r_hD     <= w_dNext;
            r_hLen   <= r_count;
            r_hErr   <= r_err;
            r_hValid <= 1'b1;
            r_state  <= STATE_DONE;
          end
        end

        STATE_DONE: begin
          if (i_h_ready) begin
            r_hValid <= 1'b0;
            r_a      <= IV_A_W;
            r_b      <= IV_B_W;
            r_c      <= IV_C_W;
            r_d      <= IV_D_W;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_sReady <= 1'b1;
            r_state  <= STATE_IDLE;
          end
        end

        default: begin
          r_state <= STATE_IDLE;
        end
      endcase
    end
  end

  // Drive the registered outputs onto the ports.
  always_comb begin
    o_s_ready = r_sReady;
    o_h_valid = r_hValid;
    o_h_a     = r_hA;
    o_h_b     = r_hB;
    o_h_c     = r_hC;
    o_h_d     = r_hD;
    o_h_len   = r_hLen;
    o_h_err   = r_hErr;
  end

  // The byte source must keep a stalled byte steady until it is accepted.
  sourceHoldsStalledByte: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      (i_s_valid && !o_s_ready) |=> ($stable(i_s_data) && $stable(i_s_last))
  );

endmodule

// File: tb/tb_hash_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_hash_stream_engine
//
// Purpose:
//   Self-checking bench for hash_stream_engine with the default parameters.
//   The stimulus side drives byte messages and pushes the expected digest
//   (from a behavioural model) into a queue. A separate monitor pops that
//   queue whenever a digest appears and compares it against the DUT outputs.
//
// Ports:
//   none (top-level bench)
// ---------------------------------------------------------------------------
module tb_hash_stream_engine;

  localparam int FINAL_ROUNDS = 4;
  localparam int MAX_BYTES    = 64;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [7:0]  len;
    logic        err;
    int          cycle;
  } digest_t;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic        h_valid;
  logic        h_ready;
  logic [15:0] h_a;
  logic [15:0] h_b;
  logic [15:0] h_c;
  logic [15:0] h_d;
  logic [7:0]  h_len;
  logic        h_err;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cycleCount  = 0;
  int          firstAccept = 0;
  int          lastAccept  = 0;
  digest_t     expQ[$];
  logic [7:0]  msgBytes[$];
  logic [15:0] mA;
  logic [15:0] mB;
  logic [15:0] mC;
  logic [15:0] mD;

  hash_stream_engine dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_s_valid (s_valid),
    .o_s_ready (s_ready),
    .i_s_data  (s_data),
    .i_s_last  (s_last),
    .o_h_valid (h_valid),
    .i_h_ready (h_ready),
    .o_h_a     (h_a),
    .o_h_b     (h_b),
    .o_h_c     (h_c),
    .o_h_d     (h_d),
    .o_h_len   (h_len),
    .o_h_err   (h_err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges. Values are read on falling edges, so after edge N
  // the count reads N.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Compare one value and record the result in the shared counters.
  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endfunction

  // Behavioural model: 16-bit words with wrap-around arithmetic.
  function automatic logic [15:0] rot16(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic void modelRound(input logic [7:0] xb);
    logic [15:0] x;
    x  = {8'h00, xb};
    mA = rot16(mA ^ x, 3) + mD;
    mB = rot16(mB + mA, 5) ^ mC;
    mC = mC + (mB ^ 16'h9E37);
    mD = rot16(mD ^ mC, 1) + x;
  endfunction

  function automatic digest_t modelDigest();
    digest_t r;
    int      count;
    logic    err;
    count = 0;
    err   = 1'b0;
    mA = 16'h6745;
    mB = 16'hEFCD;
    mC = 16'h98BA;
    mD = 16'h1032;
    foreach (msgBytes[i]) begin
      if (count == MAX_BYTES) err = 1'b1;
      else count++;
      modelRound(msgBytes[i]);
    end
    for (int k = 0; k < FINAL_ROUNDS; k++) modelRound(8'(count) ^ 8'(k));
    r.a     = mA;
    r.b     = mB;
    r.c     = mC;
    r.d     = mD;
    r.len   = 8'(count);
    r.err   = err;
    r.cycle = 0;
    return r;
  endfunction

  // Offer one byte and hold it until accepted.
  // s_ready is read on the falling edge, so the edge index recorded is the
  // rising edge that actually takes the byte.
  task automatic sendByte(input logic [7:0] d, input logic last, output int acc);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("byteAcceptTimeout", 32'(s_ready), 32'd1);
    if (s_ready) begin
      acc = cycleCount + 1;
      @(posedge clk);
    end else begin
      acc = -1;
    end
  endtask

  // Send msgBytes, inserting random idle cycles between bytes when asked.
  // If the message is closed with s_last, push its expected digest.
  task automatic applyStimulus(input int bubblePct, input bit withLast);
    int      acc;
    digest_t e;
    for (int i = 0; i < msgBytes.size(); i++) begin
      while (bubblePct > 0 && $urandom_range(99) < bubblePct) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom);
      end
      sendByte(msgBytes[i], withLast && (i == msgBytes.size() - 1), acc);
      if (i == 0) firstAccept = acc;
      lastAccept = acc;
      if (withLast && i == msgBytes.size() - 1 && acc >= 0) begin
        e       = modelDigest();
        e.cycle = acc + FINAL_ROUNDS;
        expQ.push_back(e);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Wait until every expected digest has been seen and released.
  task automatic waitDrained();
    int n;
    n = 0;
    while ((expQ.size() != 0 || h_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pendingDigests", 32'(expQ.size()), 32'd0);
    checkOutput("hValidReleased", 32'(h_valid), 32'd0);
  endtask

  // Monitor: on the first cycle of each digest, pop and compare it, including
  // the exact arrival cycle. While the digest is held, keep comparing it
  // against the same expected value.
  initial begin
    digest_t expDigest;
    logic    prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (h_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDigest", 32'(expQ.size()), 32'd1);
        end else begin
          expDigest = expQ.pop_front();
          checkOutput("digestA", 32'(h_a), 32'(expDigest.a));
          checkOutput("digestB", 32'(h_b), 32'(expDigest.b));
          checkOutput("digestC", 32'(h_c), 32'(expDigest.c));
          checkOutput("digestD", 32'(h_d), 32'(expDigest.d));
          checkOutput("digestLen", 32'(h_len), 32'(expDigest.len));
          checkOutput("digestErr", 32'(h_err), 32'(expDigest.err));
          checkOutput("digestLatency", 32'(cycleCount), 32'(expDigest.cycle));
        end
      end else if (h_valid && prevValid) begin
        checkOutput("heldA", 32'(h_a), 32'(expDigest.a));
        checkOutput("heldD", 32'(h_d), 32'(expDigest.d));
        checkOutput("heldLen", 32'(h_len), 32'(expDigest.len));
        checkOutput("sReadyWhileHeld", 32'(s_ready), 32'd0);
      end
      prevValid = h_valid;
    end
  end

  // Stimulus sequence.
  initial begin
    int n;
    int prevLast;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    h_ready = 1'b1;
    rst_n   = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("resetSReady", 32'(s_ready), 32'd0);
    checkOutput("resetHValid", 32'(h_valid), 32'd0);
    checkOutput("resetHLen", 32'(h_len), 32'd0);
    checkOutput("resetHErr", 32'(h_err), 32'd0);
    checkOutput("resetHA", 32'(h_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("sReadyAfterReset", 32'(s_ready), 32'd1);

    // Reset in the middle of a message discards that message.
    msgBytes = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    applyStimulus(0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midResetSReady", 32'(s_ready), 32'd0);
    checkOutput("midResetHValid", 32'(h_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("releaseHValid", 32'(h_valid), 32'd0);
    checkOutput("releaseSReady", 32'(s_ready), 32'd1);

    // "ABCDEF" sent back to back.
    $display("[TB] ABCDEF back-to-back");
    msgBytes = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    applyStimulus(0, 1'b1);
    waitDrained();

    // Same bytes with random bubbles; the consumer stalls for 10 clocks.
    $display("[TB] ABCDEF with bubbles and stalled consumer");
    h_ready = 1'b0;
    applyStimulus(40, 1'b1);
    n = 0;
    while (!h_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stalledDigestSeen", 32'(h_valid), 32'd1);
    repeat (10) @(negedge clk);
    h_ready = 1'b1;
    waitDrained();

    // A single zero byte.
    msgBytes = '{8'h00};
    applyStimulus(0, 1'b1);
    waitDrained();

    // 65 bytes of 0xFF overflow the 64-byte limit.
    $display("[TB] overflow message");
    msgBytes.delete();
    for (int i = 0; i < 65; i++) msgBytes.push_back(8'hFF);
    applyStimulus(0, 1'b1);
    waitDrained();

    // Two messages back to back. The second starts the cycle after the
    // first digest is released.
    msgBytes.delete();
    for (int i = 0; i < 3; i++) msgBytes.push_back(8'($urandom));
    applyStimulus(0, 1'b1);
    prevLast = lastAccept;
    msgBytes.delete();
    for (int i = 0; i < 4; i++) msgBytes.push_back(8'($urandom));
    applyStimulus(0, 1'b1);
    checkOutput("backToBackStart", 32'(firstAccept), 32'(prevLast + FINAL_ROUNDS + 2));
    waitDrained();

    // Random messages of random length with random bubbles.
    $display("[TB] random messages");
    for (int m = 0; m < 10; m++) begin
      msgBytes.delete();
      n = int'($urandom_range(70, 1));
      for (int i = 0; i < n; i++) msgBytes.push_back(8'($urandom));
      applyStimulus(int'($urandom_range(50)), 1'b1);
      waitDrained();
    end

    checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
